// File: rtl/seq_detect_sched_pkg.sv
// Shared types and default sizing for the shared serial pattern-detector scheduler.
package seq_detect_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sched_state_t;

   localparam int N_REQ_DEFAULT  = 4;
   localparam int WORD_W_DEFAULT = 8;
   localparam int PAT_W_DEFAULT  = 2;
   localparam int CNT_W_DEFAULT  = 4;

endpackage

// File: rtl/seq_detect_sched_if.sv
// Requester/status bundle between requester FSMs and seq_detect_sched.
// The abort input exists only when SEQ_DETECT_SCHED_ABORT_EN is defined.
interface seq_detect_sched_if #(
   parameter int N_REQ  = seq_detect_sched_pkg::N_REQ_DEFAULT,
   parameter int WORD_W = seq_detect_sched_pkg::WORD_W_DEFAULT,
   parameter int PAT_W  = seq_detect_sched_pkg::PAT_W_DEFAULT,
   parameter int CNT_W  = seq_detect_sched_pkg::CNT_W_DEFAULT
) ();
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*WORD_W-1:0] req_data;
   logic [PAT_W-1:0]        cfg_pattern;
`ifdef SEQ_DETECT_SCHED_ABORT_EN
   logic                    abort;
`endif
   logic [N_REQ-1:0]        req_ready;
   logic                    bit_out;
   logic                    bit_valid;
   logic                    y;
   logic                    busy;
   logic                    done;
   logic [ID_W-1:0]         done_id;
   logic [CNT_W-1:0]        match_cnt;

   modport master (
`ifdef SEQ_DETECT_SCHED_ABORT_EN
      output abort,
`endif
      output req_valid, req_data, cfg_pattern,
      input  req_ready, bit_out, bit_valid, y, busy, done, done_id, match_cnt
   );

   modport slave (
`ifdef SEQ_DETECT_SCHED_ABORT_EN
      input  abort,
`endif
      input  req_valid, req_data, cfg_pattern,
      output req_ready, bit_out, bit_valid, y, busy, done, done_id, match_cnt
   );

endinterface

// File: rtl/seq_detect_sched_det.sv
// Moore serial pattern detector: history shift register, fill counter and
// registered compare against the pattern captured on clr.
module moore_pattern_det
   import seq_detect_sched_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             bit_in,
   input  logic             bit_en,
   input  logic [PAT_W-1:0] pattern,
   output logic             y
);
   localparam int SEEN_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]  hist;
   logic [PAT_W-1:0]  hist_nxt;
   logic [PAT_W-1:0]  pat_q;
   logic [SEEN_W-1:0] seen;
   logic [SEEN_W-1:0] seen_nxt;

   // y is registered from the post-edge state, so it is a pure function of detector state
   always_comb begin
      hist_nxt = PAT_W'({hist, bit_in});
      seen_nxt = (seen == SEEN_W'(PAT_W)) ? seen : seen + SEEN_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist  <= '0;
         seen  <= '0;
         pat_q <= '0;
         y     <= 1'b0;
      end else if (clr) begin
         hist  <= '0;
         seen  <= '0;
         pat_q <= pattern;
         y     <= 1'b0;
      end else if (bit_en) begin
         hist  <= hist_nxt;
         seen  <= seen_nxt;
         y     <= (hist_nxt == pat_q) && (seen_nxt == SEEN_W'(PAT_W));
      end
   end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one Moore pattern detector across requesters.
// Define SEQ_DETECT_SCHED_ABORT_EN to add the abort input.
//
// state | meaning
// IDLE  | arbitrate; combinational one-hot req_ready, latch word on grant
// SHIFT | WORD_W cycles, serialize word MSB-first into the detector
// DONE  | one cycle, done pulse, final y folded into match_cnt
module seq_detect_sched
   import seq_detect_sched_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEFAULT,
   parameter int WORD_W = WORD_W_DEFAULT,
   parameter int PAT_W  = PAT_W_DEFAULT,
   parameter int CNT_W  = CNT_W_DEFAULT
) (
   input logic              clk,
   input logic              reset,
   seq_detect_sched_if.slave bus
);
   localparam int ID_W = $clog2(N_REQ);
   localparam int BC_W = $clog2(WORD_W + 1);

   sched_state_t      state;
   logic [WORD_W-1:0] shreg;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   cur_id;
   logic [BC_W-1:0]   bit_left;
   logic [CNT_W-1:0]  match_cnt_q;
   logic              bit_valid_q;
   logic              busy_q;
   logic              done_q;
   logic [ID_W-1:0]   done_id_q;

   logic [N_REQ-1:0]  gnt_vec;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W-1:0]   arb_idx;
   logic              gnt_any;
   logic [WORD_W-1:0] gnt_word;
   logic              abort_req;
   logic              det_y;

`ifdef SEQ_DETECT_SCHED_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   // Search starts one past the last grant; gated by reset so req_ready is 0 while in reset
   always_comb begin
      gnt_vec = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      arb_idx = '0;
      if (state == IDLE && reset) begin
         for (int k = 1; k <= N_REQ; k++) begin
            arb_idx = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!gnt_any && bus.req_valid[arb_idx]) begin
               gnt_any          = 1'b1;
               gnt_id           = arb_idx;
               gnt_vec[arb_idx] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gnt_word = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_vec[i]) gnt_word = bus.req_data[i*WORD_W +: WORD_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         shreg       <= '0;
         last_grant  <= ID_W'(N_REQ - 1);
         cur_id      <= '0;
         bit_left    <= '0;
         match_cnt_q <= '0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if ((state == SHIFT || state == DONE) && det_y && (match_cnt_q != '1))
            match_cnt_q <= match_cnt_q + CNT_W'(1);
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  shreg       <= gnt_word;
                  cur_id      <= gnt_id;
                  last_grant  <= gnt_id;
                  bit_left    <= BC_W'(WORD_W - 1);
                  match_cnt_q <= '0;
                  bit_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state       <= SHIFT;
               end
            end
            SHIFT: begin
               shreg <= shreg << 1;
               if (abort_req) begin
                  match_cnt_q <= '0;
                  bit_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end else if (bit_left == '0) begin
                  bit_valid_q <= 1'b0;
                  done_q      <= 1'b1;
                  done_id_q   <= cur_id;
                  state       <= DONE;
               end else begin
                  bit_left <= bit_left - BC_W'(1);
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   moore_pattern_det #(.PAT_W(PAT_W)) u_det (
      .clk     (clk),
      .reset   (reset),
      .clr     (gnt_any),
      .bit_in  (shreg[WORD_W-1]),
      .bit_en  (state == SHIFT),
      .pattern (bus.cfg_pattern),
      .y       (det_y)
   );

   assign bus.req_ready = gnt_vec;
   assign bus.bit_out   = shreg[WORD_W-1];
   assign bus.bit_valid = bit_valid_q;
   assign bus.y         = det_y;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.done_id   = done_id_q;
   assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: timeline model of grants/bits/counts checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_seq_detect_sched;
   localparam int W = 8;
   localparam int P = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_detect_sched_if #(.N_REQ(4), .WORD_W(8), .PAT_W(2), .CNT_W(4)) bus ();
   seq_detect_sched_if #(.N_REQ(4), .WORD_W(8), .PAT_W(2), .CNT_W(2)) bus2 ();

   seq_detect_sched #(.N_REQ(4), .WORD_W(8), .PAT_W(2), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   seq_detect_sched #(.N_REQ(4), .WORD_W(8), .PAT_W(2), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .bus(bus2));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int winner(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++) begin
         int i = (last + k) % 4;
         if (((int'(v) >> i) & 1) == 1) return i;
      end
      return -1;
   endfunction

   function automatic int bitof(input logic [7:0] w, input int j);
      return (int'(w) >> (W - j)) & 1;
   endfunction

   // 1 when the P-bit window ending at serial bit j (1-based) equals the pattern
   function automatic int win(input logic [7:0] w, input logic [1:0] p, input int j);
      int v = 0;
      if (j < P || j > W) return 0;
      for (int b = j - P + 1; b <= j; b++) v = v * 2 + bitof(w, b);
      return (v == int'(p)) ? 1 : 0;
   endfunction

   function automatic int upto(input logic [7:0] w, input logic [1:0] p, input int n);
      int c = 0;
      for (int j = 1; j <= n; j++) c += win(w, p, j);
      return c;
   endfunction

   function automatic int sat(input int x, input int cw);
      int m = (1 << cw) - 1;
      return (x > m) ? m : x;
   endfunction

   function automatic logic [7:0] word_of(input logic [31:0] d, input int i);
      logic [31:0] t = d >> (W * i);
      return t[7:0];
   endfunction

   // phase 0 = idle, 1..W = serial bit number, W+1 = done cycle
   int         m_phase, m_id, m_last;
   logic [7:0] m_word;
   logic [1:0] m_pat;
   logic       m_have, m_abort;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= 0; m_id <= 0; m_last <= 3; m_word <= '0; m_pat <= '0;
         m_have <= 1'b0; m_abort <= 1'b0;
      end else if (m_phase == 0) begin
         if (winner(bus.req_valid, m_last) >= 0) begin
            m_id    <= winner(bus.req_valid, m_last);
            m_last  <= winner(bus.req_valid, m_last);
            m_word  <= word_of(bus.req_data, winner(bus.req_valid, m_last));
            m_pat   <= bus.cfg_pattern;
            m_phase <= 1;
            m_abort <= 1'b0;
         end
      end else if (m_phase <= W) begin
`ifdef SEQ_DETECT_SCHED_ABORT_EN
         if (bus.abort) begin
            m_phase <= 0;
            m_abort <= 1'b1;
         end else m_phase <= m_phase + 1;
`else
         m_phase <= m_phase + 1;
`endif
      end else begin
         m_phase <= 0;
         m_have  <= 1'b1;
      end
   end

   task automatic compare_cycle();
      int ph = m_phase;
      int e_cnt, e_y;
      logic [63:0] e_rdy = '0;
      if (ph == 0 && reset) begin
         int g = winner(bus.req_valid, m_last);
         if (g >= 0) e_rdy = 64'(1) << g;
      end
      chk("req_ready", bus.req_ready, e_rdy);
      chk("bit_valid", bus.bit_valid, 64'(ph >= 1 && ph <= W));
      if (ph >= 1 && ph <= W) chk("bit_out", bus.bit_out, 64'(bitof(m_word, ph)));
      chk("busy", bus.busy, 64'(ph != 0));
      chk("done", bus.done, 64'(ph == W + 1));
      if (ph == W + 1) chk("done_id", bus.done_id, 64'(m_id));
      if (ph >= 1) begin
         e_cnt = sat(upto(m_word, m_pat, ph - 2), 4);
         e_y   = win(m_word, m_pat, ph - 1);
      end else if (m_abort) begin
         e_cnt = 0; e_y = -1;
      end else if (m_have) begin
         e_cnt = sat(upto(m_word, m_pat, W), 4);
         e_y   = win(m_word, m_pat, W);
      end else begin
         e_cnt = 0; e_y = 0;
      end
      chk("match_cnt", bus.match_cnt, 64'(e_cnt));
      if (e_y >= 0) chk("y", bus.y, 64'(e_y));
   endtask

   always @(negedge clk) compare_cycle();

   // ---------------- directed scenarios ----------------
   task automatic check_all_zero(input string nm);
      chk({nm, "_req_ready"}, bus.req_ready, 0);
      chk({nm, "_bit_out"}, bus.bit_out, 0);
      chk({nm, "_bit_valid"}, bus.bit_valid, 0);
      chk({nm, "_y"}, bus.y, 0);
      chk({nm, "_busy"}, bus.busy, 0);
      chk({nm, "_done"}, bus.done, 0);
      chk({nm, "_done_id"}, bus.done_id, 0);
      chk({nm, "_match_cnt"}, bus.match_cnt, 0);
   endtask

   task automatic wait_grant(input int id, input string nm, output bit got, output int g);
      got = 1'b0; g = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready == 4'(1 << id)) begin got = 1'b1; g = cyc; end
      end
      chk({nm, "_grant"}, 64'(got), 1);
   endtask

   task automatic run_word(input int id, input logic [7:0] w, input logic [1:0] p,
                           input int exp_cnt, input string nm);
      bit got; int g; int nb = 0; logic [7:0] bits = '0;
      @(posedge clk); #2;
      bus.req_data = 32'(w) << (8 * id);
      bus.cfg_pattern = p;
      bus.req_valid = 4'(1 << id);
      wait_grant(id, nm, got, g);
      if (got) begin
         @(posedge clk); #2;
         bus.req_valid = '0;
         bus.req_data = ~bus.req_data;
         bus.cfg_pattern = ~p;
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.bit_valid) begin bits = {bits[6:0], bus.bit_out}; nb++; end
            if (bus.done) begin
               got = 1'b1;
               chk({nm, "_done_latency"}, 64'(cyc - g), 9);
               chk({nm, "_done_id"}, bus.done_id, 64'(id));
            end
         end
         chk({nm, "_done_seen"}, 64'(got), 1);
         chk({nm, "_bits"}, bits, w);
         chk({nm, "_nbits"}, 64'(nb), 8);
         @(negedge clk);
         chk({nm, "_match_cnt"}, bus.match_cnt, 64'(exp_cnt));
      end
   endtask

   task automatic run_sat();
      bit got = 1'b0;
      @(posedge clk); #2;
      bus2.req_data = 32'h0000_00FF; bus2.cfg_pattern = 2'b11; bus2.req_valid = 4'b0001;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus2.req_ready == 4'b0001) got = 1'b1;
      end
      chk("sat_grant", 64'(got), 1);
      @(posedge clk); #2 bus2.req_valid = '0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus2.done) got = 1'b1;
      end
      chk("sat_done_seen", 64'(got), 1);
      @(negedge clk);
      chk("sat_match_cnt", bus2.match_cnt, 3);
   endtask

   task automatic round_robin();
      int ids[5], cy[5], n = 0;
      int exp_ids[5] = '{0, 1, 2, 3, 0};
      @(posedge clk); #2;
      bus.cfg_pattern = 2'b01; bus.req_data = 32'hA53C_0F96; bus.req_valid = 4'hF;
      for (int i = 0; i < 80 && n < 5; i++) begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            ids[n] = 0;
            for (int k = 0; k < 4; k++) if (bus.req_ready == 4'(1 << k)) ids[n] = k;
            cy[n] = cyc;
            n++;
         end
      end
      @(posedge clk); #2 bus.req_valid = '0;
      chk("rr_count", 64'(n), 5);
      for (int i = 0; i < n; i++) chk("rr_order", 64'(ids[i]), 64'(exp_ids[i]));
      for (int i = 1; i < n; i++) chk("rr_spacing", 64'(cy[i] - cy[i-1]), 10);
      repeat (12) @(posedge clk);
   endtask

   task automatic reset_mid();
      bit got; int g;
      @(posedge clk); #2;
      bus.req_data = 32'h00FF_0000; bus.cfg_pattern = 2'b11; bus.req_valid = 4'b0100;
      wait_grant(2, "rstmid", got, g);
      @(posedge clk); #2 bus.req_valid = 4'b0011;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1 check_all_zero("rstmid");
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      chk("rstmid_rr_restart", bus.req_ready, 4'b0001);
      @(posedge clk); #2 bus.req_valid = '0;
      repeat (12) @(posedge clk);
   endtask

`ifdef SEQ_DETECT_SCHED_ABORT_EN
   task automatic abort_test();
      bit got; int g;
      @(posedge clk); #2;
      bus.req_data = 32'h0000_FF00; bus.cfg_pattern = 2'b11; bus.req_valid = 4'b0010;
      wait_grant(1, "abort", got, g);
      @(posedge clk); #2 bus.req_valid = 4'b0111;
      repeat (2) @(posedge clk);
      #2 bus.abort = 1'b1;
      @(posedge clk); #2 bus.abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_match_cnt", bus.match_cnt, 0);
      chk("abort_next_grant", bus.req_ready, 4'b0100);
      @(posedge clk); #2 bus.req_valid = '0;
      repeat (12) @(posedge clk);
   endtask
`endif

   initial begin
      bus.req_valid = '0;  bus.req_data = '0;  bus.cfg_pattern = '0;
      bus2.req_valid = '0; bus2.req_data = '0; bus2.cfg_pattern = '0;
`ifdef SEQ_DETECT_SCHED_ABORT_EN
      bus.abort = 1'b0; bus2.abort = 1'b0;
`endif
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(posedge clk); #2 reset = 1'b1;

      run_sat();
      run_word(0, 8'b0101_0101, 2'b01, 4, "t1");
      run_word(2, 8'b0011_0011, 2'b01, 2, "t2a");
      run_word(1, 8'hFF,        2'b11, 7, "t2b");
      run_word(3, 8'h00,        2'b01, 0, "t2c");
      round_robin();
      reset_mid();
`ifdef SEQ_DETECT_SCHED_ABORT_EN
      abort_test();
`endif
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Scheduler that shares one Moore serial pattern detector between N_REQ word-level requesters.
- Round-robin arbiter grants one requester and latches its parallel word. The word is serialized MSB-first into an internal Moore pattern detector, then a per-word match count is reported.
- Sits between requester FSMs and the serial sequence-detector datapath; single clock domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_W, 8, bits per requested word.
- PAT_W, 2, detector pattern length in bits (1..WORD_W).
- CNT_W, 4, width of the match counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  N_REQ  per-requester word available.
- req_data  input  N_REQ*WORD_W  packed words; requester i uses bits [i*WORD_W +: WORD_W].
- cfg_pattern  input  PAT_W  pattern to detect; sampled at grant.
- req_ready  output  N_REQ  one-hot grant; the transfer occurs when valid&ready.
- bit_out  output  1  serial bit currently driven to the detector.
- bit_valid  output  1  bit_out is meaningful.
- y  output  1  Moore detector output; registered, depends on detector state only.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at word completion.
- done_id  output  $clog2(N_REQ)  requester index of the completed word.
- match_cnt  output  CNT_W  matches counted in the current/last word.

Behaviour:
- Reset values: req_ready=0, bit_out=0, bit_valid=0, y=0, busy=0, done=0, done_id=0, match_cnt=0.
- Reset internals: FSM=IDLE, last_grant=N_REQ-1, detector history cleared.
- FSM states: IDLE -> SHIFT -> DONE -> IDLE.

IDLE:
- req_ready is combinational and one-hot to the winner among asserted req_valid.
- Search order starts at last_grant+1 mod N_REQ.
- No valid requester: req_ready=0 and the FSM stays in IDLE.
- At the grant edge: latch the word into the shift register, latch id and cfg_pattern, set last_grant=id.
- Also at the grant edge: clear match_cnt and the detector (history=0, seen=0), then go to SHIFT.

SHIFT:
- Lasts exactly WORD_W cycles, with bit_valid=1 and bit_out = shreg MSB.
- Each edge shifts the register left and pushes bit_out into the detector history (PAT_W bits, newest in LSB).
- seen increments, saturating at PAT_W.
- After the WORD_W-th bit, go to DONE.

Detector:
- y = (history == latched pattern) && (seen == PAT_W), registered from detector state.
- Matches overlap, so pattern 11 on input 111 yields 2 matches.

Counting:
- match_cnt increments on every cycle in SHIFT or DONE where y=1.
- It saturates at 2^CNT_W-1, with no wrap.

DONE:
- Lasts one cycle: done=1, done_id=latched id, bit_valid=0.
- y reflects the final bit and is included in match_cnt at this edge.
- match_cnt holds its value until the next grant.

Latency:
- Grant at cycle T; bits on T+1..T+WORD_W; done at T+WORD_W+1.
- Earliest next grant is at T+WORD_W+2.

Boundary cases:
- req_valid dropping before grant: no transfer. After grant, req_valid and req_data are ignored.
- cfg_pattern changes mid-word have no effect.
- Reset asserted mid-word: immediate abort, no done pulse, all state returns to reset values, and arbitration restarts from requester 0.
- req_ready is never asserted outside IDLE.

Optional Feature:
Macro SEQ_DETECT_SCHED_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in SHIFT moves the FSM to IDLE at the next edge, with no done pulse and match_cnt cleared. last_grant still advances, so fairness is preserved. abort is ignored in IDLE and DONE.
- Undefined: no abort port; every granted word runs to DONE.

Decomposition:
- Package seq_detect_sched_pkg holds:
  - state enum sched_state_t {IDLE, SHIFT, DONE};
  - default constants for N_REQ, WORD_W, PAT_W, CNT_W.
- Sub-module moore_pattern_det instantiated once. It holds the history shift register, the seen counter, the latched pattern compare and the registered y, with ports clk, reset, clr, bit_in, bit_en, pattern, y.
- The arbiter and FSM stay in the top.

Test Plan:
All scenarios use N_REQ=4, WORD_W=8, PAT_W=2, CNT_W=4.
1. Pattern 01, req0 word 8'b0101_0101 -> grant req0; bits 0,1,0,1,0,1,0,1; done 9 cycles after grant; match_cnt=4, done_id=0.
2. Pattern 01, word 8'b0011_0011 -> match_cnt=2. Pattern 11, word 8'hFF -> match_cnt=7 (overlap). Pattern 01, word 8'h00 -> match_cnt=0.
3. All four req_valid held high -> grants in order 0,1,2,3,0, spaced 10 cycles apart; req_ready always one-hot and only asserted in IDLE.
4. reset driven low mid-SHIFT on the 4th bit -> outputs zero immediately, no done; after release with req1 and req0 both valid, req0 is granted first.
5. CNT_W=2, pattern 11, word 8'hFF -> match_cnt saturates at 3.
6. SEQ_DETECT_SCHED_ABORT_EN defined, abort pulsed at bit 3 -> back in IDLE next cycle, no done, match_cnt=0, next grant goes to last_grant+1.
